ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter RD_LATENCY, default 1: RAM read latency in cycles; legal values 1 or 2.
REQ-002 Parameter ADDR_HI, default 16: top address bit forwarded to RAM; higher bits SHALL be zero for a valid access.
REQ-003 clk  in  1  single clock; all state SHALL be on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 m0_req  in  1  requester 0 (CPU data) access request.
REQ-006 m0_wen  in  4  byte write enables; 4'b0000 means read.
REQ-007 m0_addr  in  32  byte address.
REQ-008 m0_wdata  in  32  write data.
REQ-009 m0_gnt  out  1  request accepted this cycle.
REQ-010 m0_rvalid  out  1  read data valid.
REQ-011 m0_rdata  out  32  read data.
REQ-012 m0_err  out  1  address-error response, pulses with m0_rvalid.
REQ-013 m1_req, m1_wen, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: requester 1 (loader/debug), identical widths and meanings.
REQ-014 ram_en  out  1; ram_wen  out  4; ram_addr  out  32; ram_wdata  out  32: RAM data-port drive.
REQ-015 ram_rdata  in  32  RAM read data, valid RD_LATENCY cycles after ram_en with ram_wen=0.

Function
REQ-016 Grant SHALL be combinational in the request cycle; at most one of m0_gnt/m1_gnt high per cycle.
REQ-017 A requester SHALL hold req, wen, addr, wdata stable until its gnt is seen high; req may drop only after grant.
REQ-018 Granted access with valid address SHALL drive ram_en=1 and forward winner's wen, addr, wdata in the grant cycle; otherwise ram_en=0, ram_wen=0.
REQ-019 Invalid address (any bit above ADDR_HI set) SHALL be granted with ram_en=0 and return err=1, rvalid=1, rdata=0 after RD_LATENCY cycles, for reads and writes alike.
REQ-020 Valid writes SHALL produce no rvalid response.
REQ-021 Valid read SHALL return rvalid=1, rdata=ram_rdata, err=0 to the original requester exactly RD_LATENCY cycles after grant.
REQ-022 Owner tracking SHALL use an RD_LATENCY-deep shift pipeline of {valid, owner, err}; back-to-back reads every cycle SHALL be supported without stall.
REQ-023 rdata of a non-responding requester SHALL be 0.
REQ-024 Simultaneous requests SHALL be resolved per REQ-030/031; lone request SHALL always be granted the same cycle.
REQ-025 A pointer "last_owner" SHALL update to the winner on every grant and hold otherwise.

Reset
REQ-026 On rst: gnt, rvalid, err, ram_en, ram_wen SHALL be 0; rdata 0; last_owner=1 (so m0 wins first tie).
REQ-027 Reads in flight when rst asserts SHALL be discarded; no rvalid after reset release for them.
REQ-028 No grant SHALL issue while rst is high.
REQ-029 First grant SHALL be possible in the first clock edge after rst deasserts.

Configuration
REQ-030 With RAM_ARB_ROUND_ROBIN_EN defined: tie goes to the requester not equal to last_owner (strict alternation under continuous contention).
REQ-031 Without RAM_ARB_ROUND_ROBIN_EN: fixed priority, m0 always wins ties; last_owner still maintained but unused for arbitration.

Verification
REQ-032 RD_LATENCY=1, m0 read addr 0x10, RAM returns 0xDEADBEEF -> m0_gnt same cycle, ram_addr=0x10, m0_rvalid and m0_rdata=0xDEADBEEF next cycle, m1_rvalid=0.
REQ-033 Both request reads for 4 cycles, round-robin on -> grants m0,m1,m0,m1 then in-order rvalids to matching requester; macro off -> m0 granted 4 times, m1 waits.
REQ-034 m1 write wen=4'b0011 addr 0x20 data 0x12345678 -> ram_en=1, ram_wen=4'b0011, no m1_rvalid.
REQ-035 m0 read addr 0x0002_0000 (ADDR_HI=16) -> ram_en=0, m0_rvalid=1, m0_err=1, m0_rdata=0 after RD_LATENCY.
REQ-036 RD_LATENCY=2, reads granted on two consecutive cycles, rst asserted on the following cycle -> no rvalid for either read, all outputs 0 during reset.
REQ-037 Continuous back-to-back m0 reads, RD_LATENCY=2 -> one rvalid per cycle, data order matches address order.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-requester arbiter for one RAM data port; tie policy selected by RAM_ARB_ROUND_ROBIN_EN
module ram_port_arbiter #(
    parameter int RD_LATENCY = 1,
    parameter int ADDR_HI    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [3:0]  m0_wen,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [3:0]  m1_wen,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        ram_en,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);
    // Address bits above ADDR_HI must be zero for an access to reach the RAM.
    localparam logic [31:0] VALID_MASK = (ADDR_HI >= 31) ? 32'hFFFF_FFFF
                                                         : ((32'h1 << (ADDR_HI + 1)) - 32'h1);

    logic                  last_owner;
    logic                  pick_m1;
    logic                  any_gnt;
    logic                  m0_addr_err;
    logic                  m1_addr_err;
    logic                  sel_err;
    logic [3:0]            sel_wen;
    logic [31:0]           sel_addr;
    logic [31:0]           sel_wdata;
    logic                  resp_new;
    logic [RD_LATENCY-1:0] pipe_valid;
    logic [RD_LATENCY-1:0] pipe_owner;
    logic [RD_LATENCY-1:0] pipe_err;
    logic                  out_valid;
    logic                  out_owner;
    logic                  out_err;

    assign m0_addr_err = |(m0_addr & ~VALID_MASK);
    assign m1_addr_err = |(m1_addr & ~VALID_MASK);

    // Decide which requester would win this cycle; only ties depend on the policy.
    always_comb begin
        pick_m1 = 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        if (m0_req && m1_req) begin
            pick_m1 = ~last_owner;
        end else begin
            pick_m1 = m1_req;
        end
`else
        pick_m1 = m1_req && !m0_req;
`endif
    end

    // Grants are combinational in the request cycle and suppressed while in reset.
    assign m0_gnt  = !rst && m0_req && !pick_m1;
    assign m1_gnt  = !rst && m1_req && pick_m1;
    assign any_gnt = m0_gnt || m1_gnt;

    // Steer the winner onto the RAM port; erroring or idle cycles leave the RAM untouched.
    always_comb begin
        sel_wen   = m0_wen;
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        sel_err   = m0_addr_err;
        if (m1_gnt) begin
            sel_wen   = m1_wen;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
            sel_err   = m1_addr_err;
        end
        ram_en    = any_gnt && !sel_err;
        ram_wen   = ram_en ? sel_wen : 4'b0000;
        ram_addr  = ram_en ? sel_addr : 32'h0;
        ram_wdata = ram_en ? sel_wdata : 32'h0;
        resp_new  = any_gnt && (sel_err || (sel_wen == 4'b0000));
    end

    // Response tracking pipeline, one stage per RAM latency cycle; reset drops in-flight reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            pipe_owner <= '0;
            pipe_err   <= '0;
        end else begin
            pipe_valid[0] <= resp_new;
            pipe_owner[0] <= m1_gnt;
            pipe_err[0]   <= sel_err;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_owner[i] <= pipe_owner[i-1];
                pipe_err[i]   <= pipe_err[i-1];
            end
        end
    end

    // Remember the most recent winner; starts at 1 so m0 takes the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner <= 1'b1;
        end else begin
            last_owner <= any_gnt ? m1_gnt : last_owner;
        end
    end

    assign out_valid = pipe_valid[RD_LATENCY-1];
    assign out_owner = pipe_owner[RD_LATENCY-1];
    assign out_err   = pipe_err[RD_LATENCY-1];

    assign m0_rvalid = out_valid && !out_owner;
    assign m1_rvalid = out_valid && out_owner;
    assign m0_err    = m0_rvalid && out_err;
    assign m1_err    = m1_rvalid && out_err;
    assign m0_rdata  = (m0_rvalid && !out_err) ? ram_rdata : 32'h0;
    assign m1_rdata  = (m1_rvalid && !out_err) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter at RD_LATENCY 1 and 2
`timescale 1ns/1ps
module tb_ram_port_arbiter;

    typedef struct {
        int          cyc;
        bit          owner;
        bit          err;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req, m1_req;
    logic [3:0]  m0_wen, m1_wen;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;

    logic        a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_m0_err, a_m1_err;
    logic [31:0] a_m0_rdata, a_m1_rdata;
    logic        a_ram_en;
    logic [3:0]  a_ram_wen;
    logic [31:0] a_ram_addr, a_ram_wdata, a_ram_rdata;

    logic        b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_m0_err, b_m1_err;
    logic [31:0] b_m0_rdata, b_m1_rdata;
    logic        b_ram_en;
    logic [3:0]  b_ram_wen;
    logic [31:0] b_ram_addr, b_ram_wdata, b_ram_rdata;

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    bit    tb_last  = 1'b1;
    resp_t qa[$];
    resp_t qb[$];

    always #5 clk = ~clk;

    ram_port_arbiter #(.RD_LATENCY(1), .ADDR_HI(16)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata), .m0_err(a_m0_err),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata), .m1_err(a_m1_err),
        .ram_en(a_ram_en), .ram_wen(a_ram_wen), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata),
        .ram_rdata(a_ram_rdata)
    );

    ram_port_arbiter #(.RD_LATENCY(2), .ADDR_HI(16)) u_dut_l2 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata), .m0_err(b_m0_err),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata), .m1_err(b_m1_err),
        .ram_en(b_ram_en), .ram_wen(b_ram_wen), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
        .ram_rdata(b_ram_rdata)
    );

    // RAM contents as a pure function of the byte address.
    function automatic logic [31:0] ram_fn(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    // Behavioural RAMs with one- and two-cycle read latency; garbage when no read is due.
    logic        a_v = 1'b0;
    logic [31:0] a_d = 32'h0;
    logic [1:0]  b_v = 2'b00;
    logic [31:0] b_d0 = 32'h0, b_d1 = 32'h0;
    always @(posedge clk) begin
        a_v  <= a_ram_en && (a_ram_wen == 4'b0000);
        a_d  <= ram_fn(a_ram_addr);
        b_v  <= {b_v[0], b_ram_en && (b_ram_wen == 4'b0000)};
        b_d0 <= ram_fn(b_ram_addr);
        b_d1 <= b_d0;
    end
    assign a_ram_rdata = a_v    ? a_d  : 32'hBAD0_0001;
    assign b_ram_rdata = b_v[1] ? b_d1 : 32'hBAD0_0002;

    function automatic bit predict_m1(input bit r0, input bit r1);
`ifdef RAM_ARB_ROUND_ROBIN_EN
        if (r0 && r1) return !tb_last;
`endif
        return r1 && !r0;
    endfunction

    // Record a predicted grant and queue the response it must produce on each instance.
    task automatic grant_model(input bit owner, input logic [3:0] wen, input logic [31:0] addr);
        resp_t r;
        r.owner = owner;
        r.err   = (addr[31:17] != 15'h0);
        r.data  = r.err ? 32'h0 : ram_fn(addr);
        tb_last = owner;
        if (r.err || wen == 4'b0000) begin
            r.cyc = cyc + 1;
            qa.push_back(r);
            r.cyc = cyc + 2;
            qb.push_back(r);
        end
    endtask

    task automatic score(input string name, input bit use_b, input logic v0, input logic v1,
                         input logic e0, input logic e1, input logic [31:0] d0, input logic [31:0] d1);
        resp_t       e;
        int          pend;
        logic [33:0] act, exp;
        pend = use_b ? qb.size() : qa.size();
        if (pend > 0) e = use_b ? qb[0] : qa[0];
        checks++;
        if (v0 && v1) begin
            failures++;
            $display("FAIL %s_dual_rvalid cyc=%0d actual=11 required=at most one", name, cyc);
        end else if (pend > 0 && e.cyc < cyc) begin
            failures++;
            $display("FAIL %s_missing_resp cyc=%0d actual=none required=owner %0d at cyc %0d", name, cyc, e.owner, e.cyc);
            if (use_b) void'(qb.pop_front()); else void'(qa.pop_front());
        end else if (v0 || v1) begin
            if (pend == 0 || e.cyc != cyc) begin
                failures++;
                $display("FAIL %s_spurious_rvalid cyc=%0d actual=rvalid m%0d required=no response", name, cyc, v1);
            end else begin
                if (use_b) void'(qb.pop_front()); else void'(qa.pop_front());
                act = {v1, v1 ? e1 : e0, v1 ? d1 : d0};
                exp = {e.owner, e.err, e.data};
                if (act !== exp) begin
                    failures++;
                    $display("FAIL %s_resp cyc=%0d actual=%h required=%h", name, cyc, act, exp);
                end
            end
        end
        checks++;
        if ((!v0 && (d0 !== 32'h0 || e0 !== 1'b0)) || (!v1 && (d1 !== 32'h0 || e1 !== 1'b0))) begin
            failures++;
            $display("FAIL %s_idle_zero cyc=%0d actual=%h/%b %h/%b required=0", name, cyc, d0, e0, d1, e1);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        score("l1", 1'b0, a_m0_rvalid, a_m1_rvalid, a_m0_err, a_m1_err, a_m0_rdata, a_m1_rdata);
        score("l2", 1'b1, b_m0_rvalid, b_m1_rvalid, b_m0_err, b_m1_err, b_m0_rdata, b_m1_rdata);
    endtask

    task automatic advance();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle_req();
        m0_req = 1'b0; m0_wen = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_wen = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
    endtask

    task automatic drain(input int n);
        idle_req();
        for (int i = 0; i < n; i++) begin
            sample();
            advance();
        end
    endtask

    task automatic test_reset();
        tb_last = 1'b1;
        m0_req = 1'b1; m0_addr = 32'h40;
        m1_req = 1'b1; m1_addr = 32'h44;
        sample();
        checks++;
        if ({a_m0_gnt, a_m1_gnt, b_m0_gnt, b_m1_gnt, a_ram_en, b_ram_en, a_ram_wen, b_ram_wen} !== 14'h0) begin
            failures++;
            $display("FAIL reset_outputs actual=%b%b%b%b %b%b %h %h required=all 0", a_m0_gnt, a_m1_gnt,
                     b_m0_gnt, b_m1_gnt, a_ram_en, b_ram_en, a_ram_wen, b_ram_wen);
        end
        advance();
        rst = 1'b0;
        sample();
        checks++;
        if ({a_m0_gnt, a_m1_gnt, b_m0_gnt, b_m1_gnt, a_ram_en, a_ram_addr} !== {4'b1010, 1'b1, 32'h40}) begin
            failures++;
            $display("FAIL first_grant actual=%b%b%b%b en=%b addr=%h required=1010 en=1 addr=40",
                     a_m0_gnt, a_m1_gnt, b_m0_gnt, b_m1_gnt, a_ram_en, a_ram_addr);
        end
        grant_model(1'b0, 4'h0, 32'h40);
        advance();
        m0_req = 1'b0;
        sample();
        checks++;
        if ({a_m0_gnt, a_m1_gnt, b_m0_gnt, b_m1_gnt, a_ram_addr} !== {4'b0101, 32'h44}) begin
            failures++;
            $display("FAIL lone_grant actual=%b%b%b%b addr=%h required=0101 addr=44",
                     a_m0_gnt, a_m1_gnt, b_m0_gnt, b_m1_gnt, a_ram_addr);
        end
        grant_model(1'b1, 4'h0, 32'h44);
        advance();
        drain(4);
    endtask

    task automatic test_single_read();
        idle_req();
        m0_req = 1'b1; m0_addr = 32'h10;
        sample();
        checks++;
        if ({a_m0_gnt, a_m1_gnt, b_m0_gnt, b_m1_gnt, a_ram_en, b_ram_en, a_ram_wen, a_ram_addr, b_ram_addr}
            !== {4'b1010, 2'b11, 4'h0, 32'h10, 32'h10}) begin
            failures++;
            $display("FAIL single_read_issue actual=%b%b%b%b en=%b%b wen=%h addr=%h/%h required=1010 en=11 wen=0 addr=10",
                     a_m0_gnt, a_m1_gnt, b_m0_gnt, b_m1_gnt, a_ram_en, b_ram_en, a_ram_wen, a_ram_addr, b_ram_addr);
        end
        grant_model(1'b0, 4'h0, 32'h10);
        advance();
        drain(3);
    endtask

    task automatic test_contention();
        int i0 = 0;
        int i1 = 0;
        bit g1;
        for (int c = 0; c < 12 && (i0 < 3 || i1 < 3); c++) begin
            m0_req = (i0 < 3); m0_wen = 4'h0; m0_addr = 32'h100 + 32'(4 * i0);
            m1_req = (i1 < 3); m1_wen = 4'h0; m1_addr = 32'h180 + 32'(4 * i1);
            sample();
            g1 = predict_m1(m0_req, m1_req);
            checks++;
            if ({a_m0_gnt, a_m1_gnt, b_m0_gnt, b_m1_gnt} !== {m0_req && !g1, g1, m0_req && !g1, g1}) begin
                failures++;
                $display("FAIL contention_gnt step=%0d actual=%b%b%b%b required=%b%b", c,
                         a_m0_gnt, a_m1_gnt, b_m0_gnt, b_m1_gnt, m0_req && !g1, g1);
            end
            if (g1) begin
                grant_model(1'b1, 4'h0, m1_addr);
                i1++;
            end else begin
                grant_model(1'b0, 4'h0, m0_addr);
                i0++;
            end
            advance();
        end
        checks++;
        if (i0 != 3 || i1 != 3) begin
            failures++;
            $display("FAIL contention_done actual=%0d/%0d required=3/3", i0, i1);
        end
        drain(4);
    endtask

    task automatic test_write();
        idle_req();
        m1_req = 1'b1; m1_wen = 4'b0011; m1_addr = 32'h20; m1_wdata = 32'h12345678;
        sample();
        checks++;
        if ({a_m0_gnt, a_m1_gnt, a_ram_en, a_ram_wen, a_ram_addr, a_ram_wdata, b_ram_en, b_ram_wen}
            !== {2'b01, 1'b1, 4'b0011, 32'h20, 32'h12345678, 1'b1, 4'b0011}) begin
            failures++;
            $display("FAIL write_issue actual=%b%b en=%b wen=%b addr=%h wdata=%h required=01 en=1 wen=0011 addr=20 wdata=12345678",
                     a_m0_gnt, a_m1_gnt, a_ram_en, a_ram_wen, a_ram_addr, a_ram_wdata);
        end
        grant_model(1'b1, 4'b0011, 32'h20);
        advance();
        drain(3);
    endtask

    task automatic test_addr_error();
        idle_req();
        m0_req = 1'b1; m0_addr = 32'h0002_0000;
        sample();
        checks++;
        if ({a_m0_gnt, b_m0_gnt, a_ram_en, b_ram_en, a_ram_wen, b_ram_wen} !== {2'b11, 2'b00, 8'h00}) begin
            failures++;
            $display("FAIL err_read_issue actual=%b%b en=%b%b wen=%h%h required=11 en=00 wen=00",
                     a_m0_gnt, b_m0_gnt, a_ram_en, b_ram_en, a_ram_wen, b_ram_wen);
        end
        grant_model(1'b0, 4'h0, m0_addr);
        advance();
        idle_req();
        m1_req = 1'b1; m1_wen = 4'hF; m1_addr = 32'h8000_0000; m1_wdata = 32'hCAFE0000;
        sample();
        checks++;
        if ({a_m1_gnt, a_ram_en, a_ram_wen} !== {1'b1, 1'b0, 4'h0}) begin
            failures++;
            $display("FAIL err_write_issue actual=%b en=%b wen=%h required=1 en=0 wen=0", a_m1_gnt, a_ram_en, a_ram_wen);
        end
        grant_model(1'b1, 4'hF, m1_addr);
        advance();
        idle_req();
        m0_req = 1'b1; m0_addr = 32'h0001_FFFC;
        sample();
        checks++;
        if ({a_m0_gnt, a_ram_en, a_ram_addr} !== {1'b1, 1'b1, 32'h0001_FFFC}) begin
            failures++;
            $display("FAIL top_valid_addr actual=%b en=%b addr=%h required=1 en=1 addr=0001fffc", a_m0_gnt, a_ram_en, a_ram_addr);
        end
        grant_model(1'b0, 4'h0, m0_addr);
        advance();
        drain(4);
    endtask

    task automatic test_back_to_back();
        idle_req();
        for (int i = 0; i < 8; i++) begin
            m0_req = 1'b1; m0_addr = 32'h200 + 32'(4 * i);
            sample();
            checks++;
            if ({a_m0_gnt, b_m0_gnt, b_ram_en, b_ram_addr} !== {3'b111, m0_addr}) begin
                failures++;
                $display("FAIL b2b_issue i=%0d actual=%b%b en=%b addr=%h required=11 en=1 addr=%h",
                         i, a_m0_gnt, b_m0_gnt, b_ram_en, b_ram_addr, m0_addr);
            end
            grant_model(1'b0, 4'h0, m0_addr);
            advance();
        end
        drain(4);
    endtask

    task automatic test_reset_inflight();
        idle_req();
        for (int i = 0; i < 2; i++) begin
            m0_req = 1'b1; m0_addr = 32'h300 + 32'(4 * i);
            sample();
            grant_model(1'b0, 4'h0, m0_addr);
            advance();
        end
        rst = 1'b1;
        m0_addr = 32'h308;
        qa.delete();
        qb.delete();
        for (int i = 0; i < 2; i++) begin
            sample();
            checks++;
            if ({a_m0_gnt, b_m0_gnt, a_m0_rvalid, b_m0_rvalid, a_ram_en, b_ram_en, a_ram_wen, b_ram_wen} !== 14'h0) begin
                failures++;
                $display("FAIL inflight_reset_outputs i=%0d actual=%b%b %b%b %b%b %h%h required=all 0", i,
                         a_m0_gnt, b_m0_gnt, a_m0_rvalid, b_m0_rvalid, a_ram_en, b_ram_en, a_ram_wen, b_ram_wen);
            end
            advance();
        end
        rst = 1'b0;
        tb_last = 1'b1;
        drain(4);
    endtask

    initial begin
        idle_req();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_contention();
        test_write();
        test_addr_error();
        test_back_to_back();
        test_reset_inflight();
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            failures++;
            $display("FAIL leftover_expected actual=%0d/%0d required=0/0", qa.size(), qb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
